// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory stall sequencer.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (clr_i) begin
         r_count <= '0;
      end else if (inc_i && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count_o = r_count;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory sequencer: holds the pipeline while a req/ack access is
// outstanding, then releases it for one advance cycle with the load data captured.
module dmem_stall_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             memRead_i,
   input  logic             memWrite_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic             mem_ack_i,
   input  logic [31:0]      mem_rdata_i,
   output logic [31:0]      memData_o,
   output logic             stall_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stallCount_o
);

   localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_next;
   logic              w_access;
   logic              w_stall;
   logic              w_timeout;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_req;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;

   assign w_access  = memRead_i | memWrite_i;
   // r_wcnt counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1
   assign w_timeout = (r_wcnt == WCNT_W'(TIMEOUT - 1));

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               w_stall = 1'b1;
               w_next  = WAIT;
            end
         end
         WAIT: begin
            w_stall = 1'b1;
            if (mem_ack_i || w_timeout) begin
               w_next = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  r_req   <= 1'b1;
                  r_we    <= memWrite_i;
                  r_addr  <= addr_i;
                  r_wdata <= wdata_i;
                  r_wcnt  <= '0;
               end
            end
            WAIT: begin
               r_wcnt <= r_wcnt + WCNT_W'(1);
               if (mem_ack_i) begin
                  r_req <= 1'b0;
                  if (!r_we) begin
                     r_rdata <= mem_rdata_i;
                  end
               end else if (w_timeout) begin
                  r_req   <= 1'b0;
                  r_rdata <= TIMEOUT_DATA;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .inc_i   (w_stall),
      .clr_i   (1'b0),
      .count_o (stallCount_o)
   );

   assign stall_o     = w_stall;
   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign memData_o   = r_rdata;
   assign err_o       = r_err;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed-vector bench for dmem_stall_ctrl; a second 3-bit-counter instance shares the stimulus.
module tb_dmem_stall_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        memRead_i, memWrite_i, mem_ack_i;
   logic [31:0] addr_i, wdata_i, mem_rdata_i;

   logic        req_a, we_a, stall_a, err_a;
   logic [31:0] maddr_a, mwdata_a, mdata_a;
   logic [15:0] cnt_a;

   logic        req_b, we_b, stall_b, err_b;
   logic [31:0] maddr_b, mwdata_b, mdata_b;
   logic [2:0]  cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   dmem_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .memRead_i(memRead_i), .memWrite_i(memWrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(req_a), .mem_we_o(we_a),
      .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .memData_o(mdata_a), .stall_o(stall_a),
      .err_o(err_a), .stallCount_o(cnt_a)
   );

   dmem_stall_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut3 (
      .clk_i(clk_i), .rst_i(rst_i), .memRead_i(memRead_i), .memWrite_i(memWrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(req_b), .mem_we_o(we_b),
      .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .memData_o(mdata_b), .stall_o(stall_b),
      .err_o(err_b), .stallCount_o(cnt_b)
   );

   typedef struct {
      logic        rd, wr, ack;
      logic [31:0] addr, wdata, rdata;
      logic        e_stall, e_req, e_we;
      logic [31:0] e_addr, e_wdata, e_md;
      int          e_cnt;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic ack,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata);
      memRead_i   = rd;
      memWrite_i  = wr;
      mem_ack_i   = ack;
      addr_i      = addr;
      wdata_i     = wdata;
      mem_rdata_i = rdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nst;
      //          rd  wr  ack  addr      wdata         rdata          st  rq  we  e_addr    e_wdata       e_md          cnt
      tbl[0]  = '{1'b1,1'b0,1'b0,32'h40, 32'h0,        32'h0,         1'b1,1'b0,1'b0,32'h0,  32'h0,        32'h0,        0};
      tbl[1]  = '{1'b1,1'b0,1'b0,32'h40, 32'h0,        32'h0,         1'b1,1'b1,1'b0,32'h40, 32'h0,        32'h0,        1};
      tbl[2]  = '{1'b1,1'b0,1'b0,32'h40, 32'h0,        32'h0,         1'b1,1'b1,1'b0,32'h40, 32'h0,        32'h0,        2};
      tbl[3]  = '{1'b1,1'b0,1'b1,32'h40, 32'h0,        32'h12345678,  1'b1,1'b1,1'b0,32'h40, 32'h0,        32'h0,        3};
      tbl[4]  = '{1'b1,1'b0,1'b0,32'h40, 32'h0,        32'h0,         1'b0,1'b0,1'b0,32'h40, 32'h0,        32'h12345678, 4};
      tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        32'h0,         1'b0,1'b0,1'b0,32'h40, 32'h0,        32'h12345678, 4};
      tbl[6]  = '{1'b0,1'b1,1'b0,32'h80, 32'hCAFEF00D, 32'h0,         1'b1,1'b0,1'b0,32'h40, 32'h0,        32'h12345678, 4};
      tbl[7]  = '{1'b0,1'b1,1'b1,32'h80, 32'hCAFEF00D, 32'h55555555,  1'b1,1'b1,1'b1,32'h80, 32'hCAFEF00D, 32'h12345678, 5};
      tbl[8]  = '{1'b0,1'b1,1'b0,32'h80, 32'hCAFEF00D, 32'h0,         1'b0,1'b0,1'b1,32'h80, 32'hCAFEF00D, 32'h12345678, 6};
      tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        32'h0,         1'b0,1'b0,1'b1,32'h80, 32'hCAFEF00D, 32'h12345678, 6};
      tbl[10] = '{1'b1,1'b0,1'b0,32'h100,32'h0,        32'h0,         1'b1,1'b0,1'b1,32'h80, 32'hCAFEF00D, 32'h12345678, 6};
      tbl[11] = '{1'b1,1'b0,1'b1,32'h100,32'h0,        32'hAAAA0001,  1'b1,1'b1,1'b0,32'h100,32'h0,        32'h12345678, 7};
      tbl[12] = '{1'b1,1'b0,1'b0,32'h100,32'h0,        32'h0,         1'b0,1'b0,1'b0,32'h100,32'h0,        32'hAAAA0001, 8};
      tbl[13] = '{1'b1,1'b0,1'b0,32'h104,32'h0,        32'h0,         1'b1,1'b0,1'b0,32'h100,32'h0,        32'hAAAA0001, 8};
      tbl[14] = '{1'b1,1'b0,1'b1,32'h104,32'h0,        32'hBBBB0002,  1'b1,1'b1,1'b0,32'h104,32'h0,        32'hAAAA0001, 9};
      tbl[15] = '{1'b1,1'b0,1'b0,32'h104,32'h0,        32'h0,         1'b0,1'b0,1'b0,32'h104,32'h0,        32'hBBBB0002, 10};
      tbl[16] = '{1'b0,1'b0,1'b1,32'h0,  32'h0,        32'hFFFFFFFF,  1'b0,1'b0,1'b0,32'h104,32'h0,        32'hBBBB0002, 10};
      tbl[17] = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        32'h0,         1'b0,1'b0,1'b0,32'h104,32'h0,        32'hBBBB0002, 10};

      rst_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_req",   {31'b0, req_a},   32'h0);
      chk("rst_stall", {31'b0, stall_a}, 32'h0);
      chk("rst_err",   {31'b0, err_a},   32'h0);
      chk("rst_cnt",   {16'b0, cnt_a},   32'h0);
      chk("rst_md",    mdata_a,          32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk_i);
         drive(tbl[i].rd, tbl[i].wr, tbl[i].ack, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
         #1;
         chk($sformatf("v%0d_stall", i), {31'b0, stall_a}, {31'b0, tbl[i].e_stall});
         chk($sformatf("v%0d_req", i),   {31'b0, req_a},   {31'b0, tbl[i].e_req});
         chk($sformatf("v%0d_we", i),    {31'b0, we_a},    {31'b0, tbl[i].e_we});
         chk($sformatf("v%0d_addr", i),  maddr_a,          tbl[i].e_addr);
         chk($sformatf("v%0d_wdata", i), mwdata_a,         tbl[i].e_wdata);
         chk($sformatf("v%0d_md", i),    mdata_a,          tbl[i].e_md);
         chk($sformatf("v%0d_cnt", i),   {16'b0, cnt_a},   tbl[i].e_cnt);
         chk($sformatf("v%0d_err", i),   {31'b0, err_a},   32'h0);
      end
      chk("sat_after_table", {29'b0, cnt_b}, 32'h7);

      // timeout: no ack with TIMEOUT=4
      nst = 0;
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b0, 32'h200, '0, '0);
      for (int k = 0; k < 20; k++) begin
         #1;
         if (!stall_a) break;
         nst++;
         @(negedge clk_i);
      end
      chk("to_stall_cycles", nst, 32'd5);
      chk("to_md",  mdata_a,          32'hDEADBEEF);
      chk("to_err", {31'b0, err_a},   32'h1);
      chk("to_req", {31'b0, req_a},   32'h0);
      chk("to_cnt", {16'b0, cnt_a},   32'd15);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1 chk("to_idle_stall", {31'b0, stall_a}, 32'h0);
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b0, 32'h208, '0, '0);
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b1, 32'h208, '0, 32'h600D600D);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("post_to_md",  mdata_a,        32'h600D600D);
      chk("post_to_err", {31'b0, err_a}, 32'h1);
      chk("post_to_cnt", {16'b0, cnt_a}, 32'd17);
      chk("sat_no_wrap", {29'b0, cnt_b}, 32'h7);
      @(negedge clk_i);
      #1 chk("err_sticky", {31'b0, err_a}, 32'h1);

      // asynchronous reset in the middle of WAIT
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b0, 32'h300, '0, '0);
      @(negedge clk_i);
      #1 chk("mr_req_before", {31'b0, req_a}, 32'h1);
      #2;
      rst_i = 1'b0;
      memRead_i = 1'b0;
      #1;
      chk("mr_req",   {31'b0, req_a},   32'h0);
      chk("mr_stall", {31'b0, stall_a}, 32'h0);
      chk("mr_cnt",   {16'b0, cnt_a},   32'h0);
      chk("mr_cnt3",  {29'b0, cnt_b},   32'h0);
      chk("mr_err",   {31'b0, err_a},   32'h0);
      chk("mr_addr",  maddr_a,          32'h0);
      chk("mr_md",    mdata_a,          32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 1'b1, '0, '0, 32'h77777777);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("late_ack_md",  mdata_a,        32'h0);
      chk("late_ack_req", {31'b0, req_a}, 32'h0);
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b0, 32'h304, '0, '0);
      #1 chk("clean_idle_stall", {31'b0, stall_a}, 32'h1);
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b1, 32'h304, '0, 32'h0BADF00D);
      #1;
      chk("clean_wait_stall", {31'b0, stall_a}, 32'h1);
      chk("clean_addr",       maddr_a,          32'h304);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("clean_done_stall", {31'b0, stall_a}, 32'h0);
      chk("clean_md",         mdata_a,          32'h0BADF00D);
      chk("clean_cnt",        {16'b0, cnt_a},   32'd2);
      chk("clean_cnt3",       {29'b0, cnt_b},   32'd2);
      chk("clean_err",        {31'b0, err_a},   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
